sobel_output_packer: RTL and testbench
======================================

SOBEL_OUTPUT_PACKER -- requirements
Module: sobel_output_packer

Interface
REQ-001 The block SHALL have parameter PIXEL_WIDTH, default 8, meaning the bit width of one Sobel pixel.
REQ-002 The block SHALL have parameter PACK_COUNT, default 4, meaning the number of pixels packed per output word.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8, meaning the output word FIFO depth (power of two, at least 2).
REQ-004 The block SHALL have parameter SOBEL_THRESHOLD, default 128, meaning the binarization threshold.
REQ-005 The block SHALL have port clk_i, input, 1 bit, meaning the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port nreset_i, input, 1 bit, meaning the asynchronous active-low reset.
REQ-007 The block SHALL have port px_sobel_i, input, PIXEL_WIDTH bits, meaning the Sobel magnitude from the upstream Sobel stage.
REQ-008 The block SHALL have port px_valid_i, input, 1 bit, meaning a one-cycle pulse that px_sobel_i is valid (the upstream pixel_completed_o).
REQ-009 The block SHALL have port frame_done_i, input, 1 bit, meaning that upstream preparation is complete (the upstream prep_completed_o, level).
REQ-010 The block SHALL have port out_data_o, output, PIXEL_WIDTH*PACK_COUNT bits, meaning the packed word at the FIFO head.
REQ-011 The block SHALL have port out_valid_o, output, 1 bit, meaning that the FIFO is non-empty.
REQ-012 The block SHALL have port out_ready_i, input, 1 bit, meaning the consumer accepts out_data_o; a word transfers when out_valid_o && out_ready_i.
REQ-013 The block SHALL have port px_count_o, output, 16 bits, meaning the pixels accepted in the current frame, saturating at 16'hFFFF.
REQ-014 The block SHALL have port overflow_o, output, 1 bit, meaning a sticky flag that a word was dropped.
REQ-015 The block SHALL have port frame_done_o, output, 1 bit, meaning a one-cycle pulse once the frame is fully drained.

Function
REQ-016 The FSM SHALL have states IDLE, COLLECT, FLUSH, DRAIN and DONE.
REQ-017 IDLE SHALL move to COLLECT on px_valid_i; that pixel is accepted, px_count_o is reset to 1 and overflow_o is cleared.
REQ-018 In COLLECT, each px_valid_i SHALL place the processed pixel into slot k of the pack register, k = 0..PACK_COUNT-1, with slot 0 in the LSBs, and SHALL increment px_count_o.
REQ-019 When slot PACK_COUNT-1 is filled, the full word SHALL be pushed into the FIFO in the same cycle and k SHALL wrap to 0.
REQ-020 A push when the FIFO is full and no pop occurs that cycle SHALL drop the word and set overflow_o; a push and pop in the same cycle when full SHALL both succeed.
REQ-021 Latency: a pushed word SHALL appear on out_data_o with out_valid_o high in the next cycle if the FIFO was empty.
REQ-022 frame_done_i high in COLLECT SHALL move the FSM to FLUSH if k>0, otherwise to DRAIN; if px_valid_i arrives in the same cycle, that pixel SHALL be accepted first.
REQ-023 FLUSH SHALL push the partial word with unused slots zero, stalling (never dropping) while the FIFO is full, then move to DRAIN.
REQ-024 DRAIN SHALL wait for the FIFO to be empty, then move to DONE.
REQ-025 DONE SHALL assert frame_done_o for exactly one cycle, then move to IDLE.
REQ-026 px_valid_i SHALL be ignored in FLUSH, DRAIN and DONE.
REQ-027 frame_done_i SHALL be ignored in IDLE.
REQ-028 out_data_o SHALL hold its value while out_valid_o is high and out_ready_i is low.

Reset
REQ-029 While nreset_i is low, the block SHALL hold FSM=IDLE, k=0, the FIFO empty, out_valid_o=0, out_data_o=0, px_count_o=0, overflow_o=0 and frame_done_o=0.
REQ-030 Reset asserted mid-frame SHALL discard all buffered words with no partial flush.

Configuration
REQ-031 With macro SOBEL_OUT_BINARIZE_EN defined, the processed pixel SHALL be all ones if px_sobel_i >= SOBEL_THRESHOLD and zero otherwise.
REQ-032 Without SOBEL_OUT_BINARIZE_EN, the processed pixel SHALL equal px_sobel_i unchanged.

Structure
REQ-033 The FSM state enum, default PIXEL_WIDTH and SOBEL_THRESHOLD SHALL reside in the shared sobel package used by the Sobel stages.
REQ-034 The FIFO SHALL be the sub-module sobel_out_fifo, a synchronous FIFO with push, pop, full and empty ports and registered storage.

Verification
REQ-035 Send 8 pixels 1..8, out_ready_i=1, then frame_done_i -> words 32'h04030201 and 32'h08070605, then a frame_done_o pulse, px_count_o=8.
REQ-036 Send 6 pixels 10..15, then frame_done_i -> second word 32'h00000F0E via FLUSH, then frame_done_o.
REQ-037 Hold out_ready_i=0 and send 40 pixels -> 8 words stored, overflow_o=1, 9th/10th words dropped; overflow_o clears on the next frame's first pixel.
REQ-038 With SOBEL_OUT_BINARIZE_EN defined, send 127, 128, 255, 0 -> word 32'h00FFFF00.
REQ-039 Assert nreset_i low during FLUSH with 3 words queued -> out_valid_o=0 and px_count_o=0 immediately, and no frame_done_o.
REQ-040 Pulse px_valid_i in the same cycle as frame_done_i rises -> that pixel is included in the final word.

Source files
------------

// File: rtl/sobel_output_packer_pkg.sv
// Shared Sobel package: FSM state encoding, default pixel geometry and threshold.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package sobel_output_packer_pkg;

   // Default width of one Sobel magnitude sample.
   localparam int SOBEL_PIXEL_WIDTH       = 8;
   // Default binarization threshold (pixel >= threshold becomes all ones).
   localparam int SOBEL_THRESHOLD_DEFAULT = 128;

   // Output packer frame FSM.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_FLUSH   = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_DONE    = 3'd4
   } sobel_out_state_t;

   // Saturating 16-bit increment used by the pixel counter.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/sobel_out_fifo.sv
// Synchronous word FIFO with registered storage between the pixel packer and the consumer.
// Latency: a word pushed into an empty FIFO is visible on pop_data_o the next cycle.
// Backpressure: push is refused when full unless a pop happens in the same cycle.
//
// Ports:
//   clk_i, nreset_i       clock, asynchronous active-low reset (empties the FIFO)
//   push_i, push_data_i   write request and word
//   pop_i                 read request (ignored while empty)
//   pop_data_o            head word, forced to zero while empty
//   full_o, empty_o       occupancy flags
module sobel_out_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic             clk_i,
   input  logic             nreset_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_empty;
   logic             w_full;
   logic             w_push;
   logic             w_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop   = pop_i && !w_empty;
   // When full, a simultaneous pop frees the head slot, which is the slot being written.
   assign w_push  = push_i && (!w_full || w_pop);

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data_i;
   end

   assign pop_data_o = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
   assign full_o     = w_full;
   assign empty_o    = w_empty;

endmodule

// File: rtl/sobel_output_packer.sv
// Packs Sobel pixels PACK_COUNT per word into an output FIFO and sequences frame end.
// Latency: a completed word is on out_data_o one cycle after its last pixel (FIFO empty).
// Backpressure: valid/ready output; full FIFO drops collected words (sticky overflow_o), flush stalls.
//
// Ports:
//   clk_i, nreset_i                      clock, asynchronous active-low reset
//   px_sobel_i, px_valid_i               incoming Sobel magnitude and its one-cycle strobe
//   frame_done_i                         upstream preparation complete (level)
//   out_data_o, out_valid_o, out_ready_i packed word stream (FIFO head)
//   px_count_o                           pixels accepted this frame, saturating
//   overflow_o                           sticky, a word was dropped this frame
//   frame_done_o                         one-cycle pulse after the frame has fully drained
// Build option: define SOBEL_OUT_BINARIZE_EN to threshold each pixel to all-ones/zero.
module sobel_output_packer
   import sobel_output_packer_pkg::*;
#(
   parameter int PIXEL_WIDTH     = SOBEL_PIXEL_WIDTH,
   parameter int PACK_COUNT      = 4,
   parameter int FIFO_DEPTH      = 8,
   parameter int SOBEL_THRESHOLD = SOBEL_THRESHOLD_DEFAULT
) (
   input  logic                              clk_i,
   input  logic                              nreset_i,
   input  logic [PIXEL_WIDTH-1:0]            px_sobel_i,
   input  logic                              px_valid_i,
   input  logic                              frame_done_i,
   output logic [PIXEL_WIDTH*PACK_COUNT-1:0] out_data_o,
   output logic                              out_valid_o,
   input  logic                              out_ready_i,
   output logic [15:0]                       px_count_o,
   output logic                              overflow_o,
   output logic                              frame_done_o
);

   localparam int                WORD_W    = PIXEL_WIDTH * PACK_COUNT;
   localparam int                SLOT_W    = (PACK_COUNT > 1) ? $clog2(PACK_COUNT) : 1;
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PACK_COUNT - 1);

   // Reject configurations the FIFO pointer scheme and threshold compare cannot handle.
   generate
      if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || SOBEL_THRESHOLD < 0) begin : g_bad_cfg
         $error("sobel_output_packer: FIFO_DEPTH must be a power of two >= 2, SOBEL_THRESHOLD >= 0");
      end
   endgenerate

   sobel_out_state_t   r_state;
   logic [SLOT_W-1:0]  r_slot;
   logic [WORD_W-1:0]  r_pack;
   logic [15:0]        r_px_count;
   logic               r_overflow;
   logic               r_frame_done;

   logic [PIXEL_WIDTH-1:0] w_px;
   logic [WORD_W-1:0]      w_pack_next;
   logic [WORD_W-1:0]      w_push_dat;
   logic [WORD_W-1:0]      w_fifo_dat;
   logic [SLOT_W-1:0]      w_slot_next;
   logic [SLOT_W-1:0]      w_slot_after;
   logic                   w_accept;
   logic                   w_last_slot;
   logic                   w_collect_push;
   logic                   w_flush_push;
   logic                   w_fifo_push;
   logic                   w_fifo_pop;
   logic                   w_fifo_full;
   logic                   w_fifo_empty;
   logic                   w_drop;

`ifdef SOBEL_OUT_BINARIZE_EN
   assign w_px = (32'(px_sobel_i) >= 32'(SOBEL_THRESHOLD)) ? '1 : '0;
`else
   assign w_px = px_sobel_i;
`endif

   // Pixels are only taken while a frame is being collected (IDLE starts a new one).
   assign w_accept    = px_valid_i && (r_state == ST_IDLE || r_state == ST_COLLECT);
   assign w_last_slot = (r_slot == LAST_SLOT);
   assign w_slot_next = w_last_slot ? '0 : r_slot + SLOT_W'(1);
   // Slot position after this cycle's pixel, used to decide whether a flush is needed.
   assign w_slot_after = px_valid_i ? w_slot_next : r_slot;

   // Insert the current pixel into its slot; higher slots are still zero.
   always_comb begin
      w_pack_next = r_pack;
      for (int s = 0; s < PACK_COUNT; s++) begin
         if (r_slot == SLOT_W'(s)) w_pack_next[s*PIXEL_WIDTH +: PIXEL_WIDTH] = w_px;
      end
   end

   assign w_collect_push = w_accept && w_last_slot;
   // Flush waits for room rather than losing the partial word.
   assign w_flush_push   = (r_state == ST_FLUSH) && !w_fifo_full;
   assign w_fifo_push    = w_collect_push || w_flush_push;
   assign w_push_dat     = (r_state == ST_FLUSH) ? r_pack : w_pack_next;
   assign w_fifo_pop     = !w_fifo_empty && out_ready_i;
   assign w_drop         = w_collect_push && w_fifo_full && !w_fifo_pop;

   sobel_out_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .nreset_i    (nreset_i),
      .push_i      (w_fifo_push),
      .push_data_i (w_push_dat),
      .pop_i       (w_fifo_pop),
      .pop_data_o  (w_fifo_dat),
      .full_o      (w_fifo_full),
      .empty_o     (w_fifo_empty)
   );

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         r_state      <= ST_IDLE;
         r_slot       <= '0;
         r_pack       <= '0;
         r_px_count   <= '0;
         r_overflow   <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // frame_done_i is deliberately not looked at here.
               if (px_valid_i) begin
                  r_state    <= ST_COLLECT;
                  r_slot     <= w_slot_next;
                  r_pack     <= w_last_slot ? '0 : w_pack_next;
                  r_px_count <= 16'd1;
                  r_overflow <= w_drop;
               end
            end
            ST_COLLECT: begin
               if (px_valid_i) begin
                  r_slot     <= w_slot_next;
                  r_pack     <= w_last_slot ? '0 : w_pack_next;
                  r_px_count <= sat_inc16(r_px_count);
                  if (w_drop) r_overflow <= 1'b1;
               end
               if (frame_done_i) begin
                  r_state <= (w_slot_after != '0) ? ST_FLUSH : ST_DRAIN;
               end
            end
            ST_FLUSH: begin
               if (!w_fifo_full) begin
                  r_pack  <= '0;
                  r_slot  <= '0;
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               // Pulse is registered so it coincides exactly with the DONE state.
               if (w_fifo_empty) begin
                  r_state      <= ST_DONE;
                  r_frame_done <= 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign out_data_o   = w_fifo_dat;
   assign out_valid_o  = !w_fifo_empty;
   assign px_count_o   = r_px_count;
   assign overflow_o   = r_overflow;
   assign frame_done_o = r_frame_done;

endmodule

// File: tb/tb_sobel_output_packer.sv
// Self-checking bench for sobel_output_packer: directed vector table, corner sequences, random frames.
module tb_sobel_output_packer;

   localparam int PW    = 8;
   localparam int PC    = 4;
   localparam int DEPTH = 8;

   logic        clk_i = 1'b0;
   logic        nreset_i;
   logic [7:0]  px_sobel_i;
   logic        px_valid_i;
   logic        frame_done_i;
   logic [31:0] out_data_o;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [15:0] px_count_o;
   logic        overflow_o;
   logic        frame_done_o;

   always #5 clk_i = ~clk_i;

   sobel_output_packer #(
      .PIXEL_WIDTH     (PW),
      .PACK_COUNT      (PC),
      .FIFO_DEPTH      (DEPTH),
      .SOBEL_THRESHOLD (128)
   ) dut (
      .clk_i        (clk_i),
      .nreset_i     (nreset_i),
      .px_sobel_i   (px_sobel_i),
      .px_valid_i   (px_valid_i),
      .frame_done_i (frame_done_i),
      .out_data_o   (out_data_o),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
      .px_count_o   (px_count_o),
      .overflow_o   (overflow_o),
      .frame_done_o (frame_done_o)
   );

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] rx_q[$];     // words observed leaving the DUT
   logic [31:0] exp_q[$];    // words the reference model says should leave
   logic [7:0]  px_src[$];   // pixels for the next frame
   logic [7:0]  m_pix[$];    // model: pixels of the word being assembled
   int          done_cnt;
   int          m_occ;
   int          m_phase;     // 0: accepting pixels, 1: frame ended
   bit          m_started;
   bit          m_ovf;
   int          m_cnt;

   typedef struct {
      int          n;
      int          first;
      bit          fd_last;
      int          nw;
      logic [31:0] w0;
      logic [31:0] w1;
      logic [31:0] w2;
      int          cnt;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [7:0] proc(input logic [7:0] p);
`ifdef SOBEL_OUT_BINARIZE_EN
      return (p >= 8'd128) ? 8'hFF : 8'h00;
`else
      return p;
`endif
   endfunction

   // Slot i occupies bits [8i+7:8i]; missing slots are zero.
   function automatic logic [31:0] pack_word(input logic [7:0] q[$]);
      logic [31:0] w = '0;
      for (int i = 0; i < q.size(); i++) w = w | (32'(q[i]) << (8 * i));
      return w;
   endfunction

   function automatic logic rdy_for(input int mode, input bit drain);
      if (mode == 1) return 1'($urandom_range(1));
      if (mode == 2 && !drain) return 1'b0;
      return 1'b1;
   endfunction

   task automatic new_frame();
      rx_q.delete();
      exp_q.delete();
      m_pix.delete();
      done_cnt  = 0;
      m_occ     = 0;
      m_phase   = 0;
      m_started = 0;
   endtask

   // Reference model: FIFO is an occupancy count, pops happen whenever it holds a word and
   // the consumer is ready; a completed word is lost only if no room remains after that pop.
   task automatic model_cycle(input logic pv, input logic [7:0] px, input logic fd, input logic rdy);
      bit pop_m;
      if (m_phase != 0) return;
      pop_m = (m_occ > 0) && rdy;
      if (pv) begin
         if (!m_started) begin
            m_started = 1;
            m_ovf     = 0;
            m_cnt     = 0;
         end
         m_pix.push_back(proc(px));
         if (m_cnt < 65535) m_cnt++;
         if (m_pix.size() == PC) begin
            if (m_occ < DEPTH || pop_m) begin
               exp_q.push_back(pack_word(m_pix));
               m_occ++;
            end else begin
               m_ovf = 1;
            end
            m_pix.delete();
         end
      end
      if (pop_m) m_occ--;
      if (fd && m_started) begin
         if (m_pix.size() > 0) exp_q.push_back(pack_word(m_pix));
         m_pix.delete();
         m_phase = 1;
      end
   endtask

   // One clock cycle: drive at the falling edge, observe, the DUT updates on the next rise.
   task automatic step(input logic pv, input logic [7:0] px, input logic fd, input logic rdy);
      @(negedge clk_i);
      px_valid_i   = pv;
      px_sobel_i   = px;
      frame_done_i = fd;
      out_ready_i  = rdy;
      if (out_valid_o && rdy) rx_q.push_back(out_data_o);
      if (frame_done_o) done_cnt++;
      model_cycle(pv, px, fd, rdy);
   endtask

   task automatic send_frame(input bit gaps, input int mode, input bit fd_last);
      int n = px_src.size();
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            while ($urandom_range(3) == 0) step(1'b0, 8'($urandom), 1'b0, rdy_for(mode, 0));
         end
         step(1'b1, px_src[i], fd_last && (i == n - 1), rdy_for(mode, 0));
      end
      for (int c = 0; c < 2000 && done_cnt == 0; c++)
         step(gaps ? 1'($urandom_range(1)) : 1'b0, 8'($urandom), 1'b1, rdy_for(mode, 1));
      chk("frame_done_seen", 32'(done_cnt != 0), 32'd1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
   endtask

   task automatic check_vs_model(input string tag);
      chk({tag, "_nwords"}, 32'(rx_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
         chk($sformatf("%s_word%0d", tag, i), rx_q[i], exp_q[i]);
      chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
      chk({tag, "_px_count"}, 32'(px_count_o), 32'(m_cnt));
      chk({tag, "_overflow"}, 32'(overflow_o), 32'(m_ovf));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl[7];
      logic [31:0] wexp;

      m_cnt = 0;
      m_ovf = 0;
      new_frame();
      nreset_i     = 1'b0;
      px_valid_i   = 1'b0;
      px_sobel_i   = 8'h00;
      frame_done_i = 1'b0;
      out_ready_i  = 1'b1;
      #12;
      chk("rst_out_valid", 32'(out_valid_o), 32'd0);
      chk("rst_out_data", out_data_o, 32'd0);
      chk("rst_px_count", 32'(px_count_o), 32'd0);
      chk("rst_overflow", 32'(overflow_o), 32'd0);
      chk("rst_frame_done", 32'(frame_done_o), 32'd0);
      @(negedge clk_i);
      nreset_i = 1'b1;

`ifndef SOBEL_OUT_BINARIZE_EN
      tbl[0] = '{8,  1,    1'b0, 2, 32'h04030201, 32'h08070605, 32'h0,        8};
      tbl[1] = '{6,  10,   1'b0, 2, 32'h0D0C0B0A, 32'h00000F0E, 32'h0,        6};
      tbl[2] = '{1,  'hAA, 1'b0, 1, 32'h000000AA, 32'h0,        32'h0,        1};
      tbl[3] = '{4,  'h21, 1'b0, 1, 32'h24232221, 32'h0,        32'h0,        4};
      tbl[4] = '{9,  'h30, 1'b1, 3, 32'h33323130, 32'h37363534, 32'h00000038, 9};
      tbl[5] = '{8,  'h40, 1'b1, 2, 32'h43424140, 32'h47464544, 32'h0,        8};
      tbl[6] = '{7,  'hF9, 1'b1, 2, 32'hFCFBFAF9, 32'h00FFFEFD, 32'h0,        7};
      for (int v = 0; v < 7; v++) begin
         px_src.delete();
         for (int i = 0; i < tbl[v].n; i++) px_src.push_back(8'(tbl[v].first + i));
         new_frame();
         send_frame(1'b0, 0, tbl[v].fd_last);
         chk($sformatf("tbl%0d_nwords", v), 32'(rx_q.size()), 32'(tbl[v].nw));
         for (int i = 0; i < tbl[v].nw; i++) begin
            wexp = (i == 0) ? tbl[v].w0 : (i == 1) ? tbl[v].w1 : tbl[v].w2;
            chk($sformatf("tbl%0d_word%0d", v, i), (i < rx_q.size()) ? rx_q[i] : 32'hDEADBEEF, wexp);
         end
         chk($sformatf("tbl%0d_done_pulses", v), 32'(done_cnt), 32'd1);
         chk($sformatf("tbl%0d_px_count", v), 32'(px_count_o), 32'(tbl[v].cnt));
         chk($sformatf("tbl%0d_overflow", v), 32'(overflow_o), 32'd0);
      end
`else
      px_src.delete();
      px_src.push_back(8'd127);
      px_src.push_back(8'd128);
      px_src.push_back(8'd255);
      px_src.push_back(8'd0);
      new_frame();
      send_frame(1'b0, 0, 1'b0);
      chk("bin_nwords", 32'(rx_q.size()), 32'd1);
      chk("bin_word", (rx_q.size() > 0) ? rx_q[0] : 32'hDEADBEEF, 32'h00FFFF00);
`endif

      // First-word latency and hold under backpressure.
      new_frame();
      step(1'b1, 8'h10, 1'b0, 1'b0);
      step(1'b1, 8'h11, 1'b0, 1'b0);
      step(1'b1, 8'h12, 1'b0, 1'b0);
      step(1'b1, 8'h13, 1'b0, 1'b0);
      chk("lat_valid_before", 32'(out_valid_o), 32'd0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("lat_valid_after", 32'(out_valid_o), 32'd1);
      chk("hold_data0", out_data_o, pack_word('{proc(8'h10), proc(8'h11), proc(8'h12), proc(8'h13)}));
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("hold_data1", out_data_o, pack_word('{proc(8'h10), proc(8'h11), proc(8'h12), proc(8'h13)}));
      px_src.delete();
      send_frame(1'b0, 0, 1'b0);
      check_vs_model("hold");

      // Overflow: 40 pixels with the consumer stalled, words 9 and 10 are lost.
      px_src.delete();
      for (int i = 0; i < 40; i++) px_src.push_back(8'(i));
      new_frame();
      send_frame(1'b0, 2, 1'b0);
      chk("ovf_nwords", 32'(rx_q.size()), 32'd8);
      chk("ovf_first", (rx_q.size() > 0) ? rx_q[0] : 32'hDEADBEEF, pack_word('{proc(8'd0), proc(8'd1), proc(8'd2), proc(8'd3)}));
      chk("ovf_last", (rx_q.size() > 7) ? rx_q[7] : 32'hDEADBEEF, pack_word('{proc(8'd28), proc(8'd29), proc(8'd30), proc(8'd31)}));
      chk("ovf_flag", 32'(overflow_o), 32'd1);
      chk("ovf_px_count", 32'(px_count_o), 32'd40);
      check_vs_model("ovf");
      new_frame();
      step(1'b1, 8'h55, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("ovf_cleared", 32'(overflow_o), 32'd0);
      chk("ovf_next_count", 32'(px_count_o), 32'd1);
      px_src.delete();
      send_frame(1'b0, 0, 1'b0);
      chk("ovf_next_word", (rx_q.size() > 0) ? rx_q[0] : 32'hDEADBEEF, 32'(proc(8'h55)));
      check_vs_model("ovf_next");

      // Reset during FLUSH with 3 words queued.
      new_frame();
      for (int i = 0; i < 14; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      @(negedge clk_i);
      chk("rst_pre_valid", 32'(out_valid_o), 32'd1);
      nreset_i = 1'b0;
      #1;
      chk("rst_mid_valid", 32'(out_valid_o), 32'd0);
      chk("rst_mid_count", 32'(px_count_o), 32'd0);
      chk("rst_mid_data", out_data_o, 32'd0);
      @(negedge clk_i);
      nreset_i = 1'b1;
      frame_done_i = 1'b0;
      new_frame();
      for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("rst_no_done", 32'(done_cnt), 32'd0);
      chk("rst_no_words", 32'(rx_q.size()), 32'd0);
      chk("rst_count_zero", 32'(px_count_o), 32'd0);
      m_cnt = 0;
      m_ovf = 0;

      // Random frames against the reference model.
      for (int f = 0; f < 10; f++) begin
         int n = $urandom_range(1, 50);
         px_src.delete();
         for (int i = 0; i < n; i++) px_src.push_back(8'($urandom));
         new_frame();
         send_frame(1'b1, (f % 3 == 2) ? 2 : 1, 1'($urandom_range(1)));
         check_vs_model($sformatf("rnd%0d", f));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
